// File: rtl/bus_pkg.sv
// Shared encodings for the multiplexed-address bus sequencer.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_HI = 2'd1,
        ADDR_LO = 2'd2,
        DATA    = 2'd3
    } state_e;

    localparam logic [7:0] OE_ALL  = 8'hFF;
    localparam logic [7:0] OE_NONE = 8'h00;

endpackage

// File: rtl/bus_phase_sequencer.sv
// Sequences one core access onto an 8-bit multiplexed address/data bus.
// Define BUS_WAIT_EN to let bus_wait stretch the DATA phase.
module bus_phase_sequencer
    import bus_pkg::*;
#(
    parameter logic [7:0] IDLE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_we,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [7:0]  bus_addr,
    output logic        bus_phase,
    output logic        bus_rw,
    output logic [7:0]  bus_data_out,
    output logic [7:0]  bus_data_oe,
    input  logic [7:0]  bus_data_in,
    input  logic        bus_wait
);

    state_e      state_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rdata_q;
    logic [7:0]  bus_addr_q;
    logic        bus_phase_q;
    logic        bus_rw_q;
    logic [7:0]  dout_q;
    logic [7:0]  oe_q;
    logic        data_done_d;

`ifdef BUS_WAIT_EN
    assign data_done_d = ~bus_wait;
`else
    logic unused_bus_wait;
    assign unused_bus_wait = bus_wait;
    assign data_done_d     = 1'b1;
`endif

    // Outputs are loaded with the values of the state being entered, so
    // every bus pin comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            bus_addr_q  <= IDLE_ADDR;
            bus_phase_q <= 1'b0;
            bus_rw_q    <= 1'b1;
            dout_q      <= 8'h00;
            oe_q        <= OE_NONE;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        we_q        <= req_we;
                        state_q     <= ADDR_HI;
                        req_ready_q <= 1'b0;
                        bus_addr_q  <= req_addr[15:8];
                        bus_phase_q <= 1'b0;
                        bus_rw_q    <= ~req_we;
                    end
                end
                ADDR_HI: begin
                    state_q     <= ADDR_LO;
                    bus_addr_q  <= addr_q[7:0];
                    bus_phase_q <= 1'b1;
                end
                ADDR_LO: begin
                    state_q <= DATA;
                    if (we_q) begin
                        dout_q <= wdata_q;
                        oe_q   <= OE_ALL;
                    end
                end
                DATA: begin
                    if (data_done_d) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!we_q)
                            rdata_q <= bus_data_in;
                        bus_addr_q  <= IDLE_ADDR;
                        bus_phase_q <= 1'b0;
                        bus_rw_q    <= 1'b1;
                        dout_q      <= 8'h00;
                        oe_q        <= OE_NONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign bus_addr     = bus_addr_q;
    assign bus_phase    = bus_phase_q;
    assign bus_rw       = bus_rw_q;
    assign bus_data_out = dout_q;
    assign bus_data_oe  = oe_q;

endmodule

// File: tb/tb_bus_phase_sequencer.sv
// Randomized bench for bus_phase_sequencer; expectations derived per access phase.
module tb_bus_phase_sequencer;

    localparam logic [7:0] IA = 8'hFF;
`ifdef BUS_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_we;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [7:0]  bus_addr;
    logic        bus_phase;
    logic        bus_rw;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_oe;
    logic [7:0]  bus_data_in;
    logic        bus_wait;

    int errors = 0;
    int checks = 0;
    logic [7:0] rdata_exp;

    always #5 clk = ~clk;

    bus_phase_sequencer #(.IDLE_ADDR(IA)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_addr(bus_addr), .bus_phase(bus_phase), .bus_rw(bus_rw),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .bus_data_in(bus_data_in), .bus_wait(bus_wait)
    );

    // Packed view: {req_ready, rsp_valid, bus_addr, bus_phase, bus_rw, bus_data_oe}
    function automatic logic [19:0] outs();
        return {req_ready, rsp_valid, bus_addr, bus_phase, bus_rw, bus_data_oe};
    endfunction

    // Runs one access from the core's view; called at posedge+1.
    task automatic access(input logic [15:0] a, input logic [7:0] wd, input logic we,
                          input logic [7:0] din, input int nwait, input logic hold,
                          output int waited);
        int ndata;
        logic [19:0] exp;
        req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 16) begin
            @(posedge clk); #1;
            waited++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b, required 1 within 16 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        req_addr = 16'($urandom); req_wdata = 8'($urandom); req_we = 1'($urandom);

        exp = {1'b0, 1'b0, a[15:8], 1'b0, ~we, 8'h00};
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL addr_hi a=%h: got %h, required %h", a, outs(), exp);
        end
        @(posedge clk); #1;
        exp = {1'b0, 1'b0, a[7:0], 1'b1, ~we, 8'h00};
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL addr_lo a=%h: got %h, required %h", a, outs(), exp);
        end

        ndata = WAIT_EN ? nwait + 1 : 1;
        for (int i = 0; i < ndata; i++) begin
            @(posedge clk); #1;
            exp = {1'b0, 1'b0, a[7:0], 1'b1, ~we, (we ? 8'hFF : 8'h00)};
            checks++;
            if (outs() !== exp) begin
                errors++; $display("FAIL data[%0d] a=%h: got %h, required %h", i, a, outs(), exp);
            end
            if (we) begin
                checks++;
                if (bus_data_out !== wd) begin
                    errors++; $display("FAIL data_out: got %h, required %h", bus_data_out, wd);
                end
            end
            bus_wait    = (i < nwait);
            bus_data_in = (i == ndata - 1) ? din : 8'($urandom);
        end

        @(posedge clk); #1;
        bus_wait = 1'b0; bus_data_in = 8'($urandom);
        if (!we) rdata_exp = din;
        exp = {1'b1, 1'b1, IA, 1'b0, 1'b1, 8'h00};
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL rsp_cycle a=%h: got %h, required %h", a, outs(), exp);
        end
        checks++;
        if (rsp_rdata !== rdata_exp) begin
            errors++; $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, rdata_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0; req_wdata = 8'h0; req_we = 1'b0;
        bus_data_in = 8'h00; bus_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({outs(), rsp_rdata, bus_data_out} !== {1'b1, 1'b0, IA, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00}) begin
            errors++; $display("FAIL reset_values: got %h, required %h",
                {outs(), rsp_rdata, bus_data_out}, {1'b1, 1'b0, IA, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00});
        end
        rst = 1'b0;
        rdata_exp = 8'h00;
        @(posedge clk); #1;
        checks++;
        if (outs() !== {1'b1, 1'b0, IA, 1'b0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL idle_after_reset: got %h", outs());
        end
    endtask

    task automatic test_read_write();
        int w;
        access(16'hA55A, 8'h00, 1'b0, 8'h3C, 0, 1'b0, w);
        access(16'h1234, 8'hE7, 1'b1, 8'($urandom), 0, 1'b0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        access(16'h0001, 8'h00, 1'b0, 8'($urandom), 0, 1'b1, w);
        access(16'h0002, 8'h00, 1'b0, 8'($urandom), 0, 1'b0, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL back_to_back_gap: waited %0d cycles, required 0", w);
        end
    endtask

    task automatic test_reset_mid_access();
        int w;
        req_valid = 1'b1; req_addr = 16'($urandom); req_we = 1'b0; req_wdata = 8'h00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        rdata_exp = 8'h00;
        checks++;
        if ({outs(), rsp_rdata, bus_data_out} !== {1'b1, 1'b0, IA, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00}) begin
            errors++; $display("FAIL async_reset: got %h", {outs(), rsp_rdata, bus_data_out});
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
        end
        rst = 1'b0;
        access(16'($urandom), 8'h00, 1'b0, 8'($urandom), 0, 1'b0, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL accept_after_reset: waited %0d cycles, required 0", w);
        end
    endtask

    task automatic test_wait_states();
        int w;
        access(16'hBEEF, 8'h00, 1'b0, 8'h96, 3, 1'b0, w);
        access(16'h4321, 8'h5A, 1'b1, 8'($urandom), 2, 1'b0, w);
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 24; n++) begin
            access(16'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), w);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
                checks++;
                if (outs() !== {1'b1, 1'b0, IA, 1'b0, 1'b1, 8'h00}) begin
                    errors++; $display("FAIL idle_gap: got %h", outs());
                end
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rsp_single_pulse: got %b, required 0", rsp_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_write();
        test_back_to_back();
        test_reset_mid_access();
        test_wait_states();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
